// File: rtl/demux_c.sv
// demux_c: rebuilds N_LANES-bit words from the serial 2:1 mux stream, one bit per lane.
// Define DEMUX_ERR_CNT_EN to add the saturating 8-bit duplicate-lane counter err_cnt.
module demux_c #(
    parameter int N_LANES   = 2,
    parameter int SEL_W     = 1,
    parameter int SEL_DELAY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_data,
    input  logic [SEL_W-1:0]   sel,
    input  logic               in_valid,
    output logic [N_LANES-1:0] data_out,
    output logic               out_valid,
    output logic               overrun,
    output logic               busy
`ifdef DEMUX_ERR_CNT_EN
    ,
    output logic [7:0]         err_cnt
`endif
);
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    logic [0:0]         state;
    logic [SEL_W-1:0]   e_sel;
    logic               e_valid;
    logic [N_LANES-1:0] bitmap, shadow, lane_mask, new_map, new_shadow;
    logic               hit, dup, done;

    // The mux registers its output, so sel/valid lag one cycle to line up with in_data.
    generate
        if (SEL_DELAY != 0) begin : g_dly
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    e_sel   <= '0;
                    e_valid <= 1'b0;
                end else begin
                    e_sel   <= sel;
                    e_valid <= in_valid;
                end
            end
        end else begin : g_direct
            assign e_sel   = sel;
            assign e_valid = in_valid;
        end
    endgenerate

    always_comb begin
        hit        = e_valid && (32'(e_sel) < N_LANES);
        lane_mask  = hit ? N_LANES'(1) << e_sel : '0;
        dup        = |(lane_mask & bitmap);
        new_map    = bitmap | lane_mask;
        new_shadow = in_data ? shadow | lane_mask : shadow & ~lane_mask;
        done       = hit && &new_map;
    end

    assign busy = state == COLLECT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bitmap    <= '0;
            shadow    <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= done;
            overrun   <= overrun | dup;
            shadow    <= new_shadow;
            bitmap    <= done ? '0 : new_map;
            state     <= (!done && |new_map) ? COLLECT : IDLE;
            if (done)
                data_out <= new_shadow;
        end
    end

`ifdef DEMUX_ERR_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_cnt <= '0;
        else if (dup && err_cnt != 8'hff)
            err_cnt <= err_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_demux_c.sv
// tb_demux_c: scoreboard bench for demux_c, one instance per SEL_DELAY setting.
// Expected words and completion cycles are queued at issue time and popped on out_valid.
module tb_demux_c;
    logic       clk = 1'b0, reset = 1'b1, in_data = 1'b0, in_valid = 1'b0, d_dly;
    logic [1:0] sel = '0;
    logic [1:0] do0, do1;
    logic       ov0, ov1, or0, or1, b0, b1;
`ifdef DEMUX_ERR_CNT_EN
    logic [7:0] ec0, ec1;
`endif
    int checks = 0, errors = 0, cyc = 0;

    typedef struct {
        logic [1:0] w;
        int         c;
    } exp_t;
    exp_t q0[$], q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Models the mux output register feeding the delayed-sel instance.
    always @(posedge clk or posedge reset) d_dly <= reset ? 1'b0 : in_data;

    demux_c #(.N_LANES(2), .SEL_W(2), .SEL_DELAY(0)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .sel(sel), .in_valid(in_valid),
        .data_out(do0), .out_valid(ov0), .overrun(or0), .busy(b0)
`ifdef DEMUX_ERR_CNT_EN
        , .err_cnt(ec0)
`endif
    );

    demux_c #(.N_LANES(2), .SEL_W(2), .SEL_DELAY(1)) dut1 (
        .clk(clk), .reset(reset), .in_data(d_dly), .sel(sel), .in_valid(in_valid),
        .data_out(do1), .out_valid(ov1), .overrun(or1), .busy(b1)
`ifdef DEMUX_ERR_CNT_EN
        , .err_cnt(ec1)
`endif
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (ov0) begin
                if (q0.size() == 0) chk("dut0 unexpected pulse", 1, 0);
                else begin
                    e = q0.pop_front();
                    chk("dut0 word", 32'(do0), 32'(e.w));
                    chk("dut0 latency", cyc, e.c);
                end
            end
            if (ov1) begin
                if (q1.size() == 0) chk("dut1 unexpected pulse", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("dut1 word", 32'(do1), 32'(e.w));
                    chk("dut1 latency", cyc, e.c);
                end
            end
        end
    end

    task automatic send(input logic [1:0] s, input logic d, input bit fin = 0, input logic [1:0] w = 0);
        exp_t e;
        @(posedge clk);
        #1;
        sel = s;
        in_data = d;
        in_valid = 1'b1;
        if (fin) begin
            e.w = w;
            e.c = cyc + 1;
            q0.push_back(e);
            e.c = cyc + 2;
            q1.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    initial begin
        logic [1:0] wv;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs dut0", {do0, ov0, or0, b0}, 0);
        chk("reset outputs dut1", {do1, ov1, or1, b1}, 0);
        reset = 1'b0;
        // lane 0 then lane 1
        send(0, 1);
        send(1, 0, 1, 2'b01);
        chk("busy after first lane", b0, 1);
        idle(1);
        chk("busy clear dut0", b0, 0);
        chk("busy set dut1", b1, 1);
        idle(1);
        chk("busy clear dut1", b1, 0);
        idle(2);
        // reversed lane order
        send(1, 1);
        send(0, 1, 1, 2'b11);
        idle(3);
        // long gap between lanes
        send(1, 0);
        idle(10);
        chk("busy held dut0", b0, 1);
        chk("busy held dut1", b1, 1);
        send(0, 1, 1, 2'b01);
        idle(3);
        // out-of-range lanes are ignored
        send(2, 1);
        send(3, 1);
        idle(2);
        chk("out of range no busy dut0", b0, 0);
        chk("out of range no busy dut1", b1, 0);
        send(0, 0);
        send(3, 1);
        send(1, 1, 1, 2'b10);
        idle(3);
        chk("no overrun yet dut0", or0, 0);
        // mux loopback sweep
        for (int w = 0; w < 4; w++) begin
            wv = w[1:0];
            send(0, wv[0]);
            send(1, wv[1], 1, wv);
        end
        idle(3);
        chk("loopback overrun dut0", or0, 0);
        chk("loopback overrun dut1", or1, 0);
        // duplicate lane: newest wins, overrun sticky
        send(0, 1);
        send(0, 0);
        send(1, 1, 1, 2'b10);
        idle(3);
        chk("overrun dut0", or0, 1);
        chk("overrun dut1", or1, 1);
`ifdef DEMUX_ERR_CNT_EN
        chk("err_cnt one dut0", ec0, 1);
        chk("err_cnt one dut1", ec1, 1);
`endif
        send(1, 0);
        send(0, 0, 1, 2'b00);
        idle(3);
        chk("overrun sticky", or0, 1);
`ifdef DEMUX_ERR_CNT_EN
        send(0, 1);
        repeat (300) send(0, 1);
        idle(3);
        chk("err_cnt saturates dut0", ec0, 255);
        chk("err_cnt saturates dut1", ec1, 255);
        send(1, 1, 1, 2'b11);
        idle(3);
`endif
        // async reset mid-word discards the partial word
        send(1, 1);
        idle(2);
        chk("partial busy", b0, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset dut0", {do0, ov0, or0, b0}, 0);
        chk("async reset dut1", {do1, ov1, or1, b1}, 0);
`ifdef DEMUX_ERR_CNT_EN
        chk("async reset err_cnt", ec0, 0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(0, 1);
        idle(3);
        chk("bitmap cleared dut0", b0, 1);
        chk("bitmap cleared dut1", b1, 1);
        send(1, 0, 1, 2'b01);
        idle(4);
        chk("queue0 drained", q0.size(), 0);
        chk("queue1 drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
